// File: rtl/serializer_pkg.sv
// Shared types and constants for the 8:1 serializer.
// SERIALIZER_8_TO_1_PARITY_EN adds a trailing even-parity beat.
package serializer_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

`ifdef SERIALIZER_8_TO_1_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
`endif

  function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
    return msb_first ? SEL_W'(WORD_W - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_end(input bit msb_first);
    return msb_first ? '0 : SEL_W'(WORD_W - 1);
  endfunction

endpackage

// File: rtl/mux_8_to_1.sv
// Plain 8:1 bit multiplexer.
// Purely combinational; the serializer drives its select.
module mux_8_to_1
  import serializer_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic              out
);

  assign out = in[sel];

endmodule

// File: rtl/serializer_8_to_1.sv
// Valid/ready 8-bit parallel-to-serial stage wrapping mux_8_to_1.
// SERIALIZER_8_TO_1_PARITY_EN appends an even-parity beat per word.
module serializer_8_to_1
  import serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit IDLE_OUT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam logic [SEL_W-1:0] SEL_START = sel_start(MSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_END   = sel_end(MSB_FIRST);

  ser_state_t        state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              mux_bit;
  logic              out_bit;
  logic              accept;
  logic              load;
  logic [SEL_W-1:0]  sel_step;

  mux_8_to_1 u_mux (
    .in  (data_q),
    .sel (sel_q),
    .out (mux_bit)
  );

  assign accept   = out_valid_q && out_ready;
  assign in_ready = !rst &&
                    ((state_q == IDLE) || (out_last_q && accept));
  assign load     = in_valid && in_ready;
  assign sel_step = MSB_FIRST ? sel_q - SEL_W'(1)
                              : sel_q + SEL_W'(1);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (load) begin
      state_d     = SHIFT;
      data_d      = in_data;
      sel_d       = SEL_START;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SHIFT: begin
          if (accept) begin
            if (sel_q == SEL_END) begin
`ifdef SERIALIZER_8_TO_1_PARITY_EN
              state_d    = PARITY;
              out_last_d = 1'b1;
`else
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
`endif
            end else begin
              sel_d = sel_step;
`ifndef SERIALIZER_8_TO_1_PARITY_EN
              out_last_d = (sel_step == SEL_END);
`endif
            end
          end
        end
`ifdef SERIALIZER_8_TO_1_PARITY_EN
        PARITY: begin
          if (accept) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      sel_q       <= SEL_START;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef SERIALIZER_8_TO_1_PARITY_EN
  assign out_bit = (state_q == PARITY) ? ^data_q : mux_bit;
`else
  assign out_bit = mux_bit;
`endif

  assign out       = out_valid_q ? out_bit : IDLE_OUT;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serializer_8_to_1.sv
// Directed bench: LSB-first and MSB-first instances share stimulus.
// Parity-aware when SERIALIZER_8_TO_1_PARITY_EN is defined.
module tb_serializer_8_to_1;

`ifdef SERIALIZER_8_TO_1_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready0, out0, out_valid0, out_last0, busy0;
  logic [2:0] sel0;
  logic       in_ready1, out1, out_valid1, out_last1, busy1;
  logic [2:0] sel1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serializer_8_to_1 #(.MSB_FIRST(1'b0), .IDLE_OUT(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .sel       (sel0),
    .out       (out0),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_last  (out_last0),
    .busy      (busy0)
  );

  serializer_8_to_1 #(.MSB_FIRST(1'b1), .IDLE_OUT(1'b1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .sel       (sel1),
    .out       (out1),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_last  (out_last1),
    .busy      (busy1)
  );

  // {valid, sel[2:0], out, last} expected for beat b of word w
  function automatic logic [5:0] exp_beat(input logic [7:0] w,
                                          input int b,
                                          input bit msb);
    logic [2:0] s;
    logic       o;
    if (b < 8) begin
      s = msb ? 3'(7 - b) : 3'(b);
      o = w[s];
    end else begin
      s = msb ? 3'd0 : 3'd7;
      o = ^w;
    end
    return {1'b1, s, o, (b == NB - 1)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 8'h00;
    @(negedge clk);
    #1;
    tests++;
    if ({in_ready0, out_valid0, out_last0, busy0, out0} !== 5'b0) begin
      fails++;
      $display("FAIL rst_flags0 got %b want 00000",
               {in_ready0, out_valid0, out_last0, busy0, out0});
    end
    tests++;
    if (sel0 !== 3'd0) begin
      fails++;
      $display("FAIL rst_sel0 got %0d want 0", sel0);
    end
    tests++;
    if ({sel1, out1, out_valid1, in_ready1} !== {3'd7, 1'b1, 2'b00}) begin
      fails++;
      $display("FAIL rst_dut1 got %b want 111100",
               {sel1, out1, out_valid1, in_ready1});
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready0 !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_in_ready got %b want 1", in_ready0);
    end
  endtask

  task automatic test_lsb_first();
    logic [5:0] e;
    @(negedge clk);
    in_data = 8'b1011_0010;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready0 !== 1'b1) begin
      fails++;
      $display("FAIL lsb_in_ready got %b want 1", in_ready0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < NB; b++) begin
      #1;
      e = exp_beat(8'b1011_0010, b, 1'b0);
      tests++;
      if ({out_valid0, sel0, out0, out_last0} !== e) begin
        fails++;
        $display("FAIL lsb_beat%0d got %b want %b", b,
                 {out_valid0, sel0, out0, out_last0}, e);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if ({busy0, out_valid0, out0, sel0} !== {3'b000, 3'd7}) begin
      fails++;
      $display("FAIL lsb_after got %b want 000111",
               {busy0, out_valid0, out0, sel0});
    end
  endtask

  task automatic test_msb_first();
    logic [5:0] e;
    @(negedge clk);
    in_data = 8'b1011_0010;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < NB; b++) begin
      #1;
      e = exp_beat(8'b1011_0010, b, 1'b1);
      tests++;
      if ({out_valid1, sel1, out1, out_last1} !== e) begin
        fails++;
        $display("FAIL msb_beat%0d got %b want %b", b,
                 {out_valid1, sel1, out1, out_last1}, e);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if ({busy1, out_valid1, out1, sel1} !== {3'b001, 3'd0}) begin
      fails++;
      $display("FAIL msb_after got %b want 001000",
               {busy1, out_valid1, out1, sel1});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    logic [7:0] w;
    int         k;
    @(negedge clk);
    in_data = 8'hA5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    @(negedge clk);
    in_data = 8'h3C;
    for (int b = 0; b < 2 * NB; b++) begin
      if (b == 2 * NB - 1) in_valid = 1'b0;
      #1;
      w = (b < NB) ? 8'hA5 : 8'h3C;
      k = b % NB;
      e = exp_beat(w, k, 1'b0);
      tests++;
      if ({out_valid0, sel0, out0, out_last0} !== e) begin
        fails++;
        $display("FAIL b2b_beat%0d got %b want %b", b,
                 {out_valid0, sel0, out0, out_last0}, e);
      end
      tests++;
      if (in_ready0 !== (k == NB - 1)) begin
        fails++;
        $display("FAIL b2b_in_ready%0d got %b want %b", b,
                 in_ready0, (k == NB - 1));
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if ({busy0, out_valid0} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_after got %b want 00", {busy0, out_valid0});
    end
  endtask

  task automatic test_stall();
    logic [5:0] e;
    int cnt = 0;
    int cyc = 0;
    @(negedge clk);
    in_data = 8'hF0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    while (cnt < NB && cyc < 64) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      e = exp_beat(8'hF0, cnt, 1'b0);
      tests++;
      if ({out_valid0, sel0, out0, out_last0} !== e) begin
        fails++;
        $display("FAIL stall_cyc%0d got %b want %b", cyc,
                 {out_valid0, sel0, out0, out_last0}, e);
      end
      if (out_ready) cnt++;
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (cnt != NB) begin
      fails++;
      $display("FAIL stall_timeout got %0d beats want %0d", cnt, NB);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if ({busy0, out_valid0} !== 2'b00) begin
      fails++;
      $display("FAIL stall_after got %b want 00", {busy0, out_valid0});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_data = 8'hFF;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({out_valid0, sel0, out0} !== {1'b1, 3'd3, 1'b1}) begin
      fails++;
      $display("FAIL midrst_pre got %b want 10111",
               {out_valid0, sel0, out0});
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({out_valid0, out0, sel0, busy0, in_ready0} !== 7'b0) begin
      fails++;
      $display("FAIL midrst_dut0 got %b want 0000000",
               {out_valid0, out0, sel0, busy0, in_ready0});
    end
    tests++;
    if ({out_valid1, out1, sel1} !== {1'b0, 1'b1, 3'd7}) begin
      fails++;
      $display("FAIL midrst_dut1 got %b want 01111",
               {out_valid1, out1, sel1});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      tests++;
      if ({out_valid0, busy0, out_valid1} !== 3'b000) begin
        fails++;
        $display("FAIL midrst_idle%0d got %b want 000", i,
                 {out_valid0, busy0, out_valid1});
      end
    end
  endtask

`ifdef SERIALIZER_8_TO_1_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       par   [2];
    words[0] = 8'b0000_0111;
    words[1] = 8'h03;
    par[0] = 1'b1;
    par[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      in_data = words[j];
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      tests++;
      if ({out_valid0, sel0, out0, out_last0} !==
          {1'b1, 3'd7, par[j], 1'b1}) begin
        fails++;
        $display("FAIL parity%0d got %b want %b", j,
                 {out_valid0, sel0, out0, out_last0},
                 {1'b1, 3'd7, par[j], 1'b1});
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef SERIALIZER_8_TO_1_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
